// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Imported by mem_port_arbiter and arb_streak_counter.
package arb_types;

   typedef enum logic [1:0] {
      IDLE,
      I_BUSY,
      D_BUSY
   } arb_state_t;

   typedef enum logic {
      ARB_RD,
      ARB_WR
   } arb_kind_t;

   // Wide enough for any byte-enable width; sliced to size by users.
   localparam logic [127:0] ARB_MBE_ALL = '1;

   localparam int ARB_STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// Saturating count of consecutive data grants won while a fetch waits.
// at_limit forces the next grant to the fetch port.
import arb_types::*;

module arb_streak_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic at_limit
);

   localparam logic [ARB_STREAK_W-1:0] LIM = ARB_STREAK_W'(STARVE_LIMIT);

   logic [ARB_STREAK_W-1:0] count;

   // count up to LIM, cleared by an instruction grant
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && count != LIM)
         count <= count + 1'b1;
   end

   assign at_limit = (count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges fetch and load/store ports onto one word-wide memory port.
// Optional macro ARB_PERF_CNT_EN adds grant and fetch-wait counters.
import arb_types::*;

module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inst_read,
   input  logic [ADDR_WIDTH-1:0]   inst_addr,
   output logic                    inst_resp,
   output logic [DATA_WIDTH-1:0]   inst_rdata,
   input  logic                    data_read,
   input  logic                    data_write,
   input  logic [DATA_WIDTH/8-1:0] data_mbe,
   input  logic [ADDR_WIDTH-1:0]   data_addr,
   input  logic [DATA_WIDTH-1:0]   data_wdata,
   output logic                    data_resp,
   output logic [DATA_WIDTH-1:0]   data_rdata,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [DATA_WIDTH/8-1:0] mem_mbe,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_resp
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]             perf_i_grants,
   output logic [31:0]             perf_d_grants,
   output logic [31:0]             perf_i_wait
`endif
);

   localparam int MW = DATA_WIDTH / 8;
   localparam logic [MW-1:0] MBE_ALL = ARB_MBE_ALL[MW-1:0];

   arb_state_t state;
   arb_state_t state_next;
   arb_kind_t  kind;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [MW-1:0]         mbe_q;

   logic data_req;
   logic at_limit;
   logic grant_d;
   logic grant_i;

   assign data_req = data_read | data_write;
   assign grant_d  = (state == IDLE) && data_req && (!inst_read || !at_limit);
   assign grant_i  = (state == IDLE) && !grant_d && inst_read;

   arb_streak_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_streak (
      .clk      (clk),
      .rst      (rst),
      .clr      (grant_i),
      .inc      (grant_d && inst_read),
      .at_limit (at_limit)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // next state: grant from IDLE, return to IDLE on completion
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (grant_d)
               state_next = D_BUSY;
            else if (grant_i)
               state_next = I_BUSY;
         end
         I_BUSY, D_BUSY: begin
            if (mem_resp)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // capture the winning request so upstream changes are ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         mbe_q   <= '0;
         kind    <= ARB_RD;
      end else if (grant_d) begin
         addr_q  <= data_addr;
         wdata_q <= data_wdata;
         mbe_q   <= data_write ? data_mbe : MBE_ALL;
         kind    <= data_write ? ARB_WR : ARB_RD;
      end else if (grant_i) begin
         addr_q  <= inst_addr;
         mbe_q   <= MBE_ALL;
         kind    <= ARB_RD;
      end
   end

   // drive the shared port and route completions by owner
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_mbe   = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      inst_resp = 1'b0;
      data_resp = 1'b0;
      unique case (state)
         I_BUSY: begin
            mem_read  = 1'b1;
            mem_addr  = addr_q;
            mem_mbe   = mbe_q;
            inst_resp = mem_resp;
         end
         D_BUSY: begin
            mem_read  = (kind == ARB_RD);
            mem_write = (kind == ARB_WR);
            mem_addr  = addr_q;
            mem_mbe   = mbe_q;
            mem_wdata = wdata_q;
            data_resp = mem_resp;
         end
         default: begin
         end
      endcase
   end

   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

`ifndef SYNTHESIS
   // a simultaneous load and store is served as a store; flag it
   always_ff @(posedge clk) begin
      if (!rst && state == IDLE)
         assert (!(data_read && data_write))
         else $warning("data_read and data_write both high");
   end
`endif

`ifdef ARB_PERF_CNT_EN
   // saturating grant and fetch-stall counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_grants <= '0;
         perf_d_grants <= '0;
         perf_i_wait   <= '0;
      end else begin
         if (grant_i && perf_i_grants != 32'hFFFF_FFFF)
            perf_i_grants <= perf_i_grants + 1'b1;
         if (grant_d && perf_d_grants != 32'hFFFF_FFFF)
            perf_d_grants <= perf_d_grants + 1'b1;
         if (inst_read && state != I_BUSY && perf_i_wait != 32'hFFFF_FFFF)
            perf_i_wait <= perf_i_wait + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps then random traffic.
// A transaction-level model predicts grants, port strobes and responses.
module tb_mem_port_arbiter;

   localparam int LIM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_read = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        inst_resp;
   logic [31:0] inst_rdata;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [3:0]  data_mbe = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic        data_resp;
   logic [31:0] data_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_mbe;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_i_grants;
   logic [31:0] perf_d_grants;
   logic [31:0] perf_i_wait;
`endif

   mem_port_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (LIM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_read  (inst_read),
      .inst_addr  (inst_addr),
      .inst_resp  (inst_resp),
      .inst_rdata (inst_rdata),
      .data_read  (data_read),
      .data_write (data_write),
      .data_mbe   (data_mbe),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_resp  (data_resp),
      .data_rdata (data_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_mbe    (mem_mbe),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_i_grants (perf_i_grants),
      .perf_d_grants (perf_d_grants),
      .perf_i_wait   (perf_i_wait)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // transaction-level model: who owns the port and what it asked for
   bit          mb = 0;
   bit          mown = 0;
   bit          mwr = 0;
   logic [31:0] maddr = '0;
   logic [31:0] mwdata = '0;
   logic [3:0]  mmbe = '0;
   int          mwait = 0;
   int          mstreak = 0;
   int          pi = 0;
   int          pd = 0;
   int          pw = 0;

   bit          rnd = 0;
   bit          force_resp = 0;
   bit          rec = 0;
   int          dwait = 0;
   logic [31:0] next_rdata = '0;
   string       gs = "";

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // one cycle of observation: memory reply, output checks, requester drop
   task automatic observe();
      @(negedge clk);
      if (mb) begin
         if (mwait == 0) begin
            mem_resp  = 1'b1;
            mem_rdata = next_rdata;
         end else begin
            mem_resp = 1'b0;
            mwait--;
         end
      end else begin
         mem_resp  = force_resp | (rnd && $urandom_range(0, 7) == 0);
         mem_rdata = $urandom;
      end
      if (rnd) next_rdata = $urandom;
      #1;
      chk("mem_read", mem_read, mb && (!mown || !mwr));
      chk("mem_write", mem_write, mb && mown && mwr);
      if (mb) begin
         chk("mem_addr", mem_addr, maddr);
         chk("mem_mbe", mem_mbe, mmbe);
         if (mwr) chk("mem_wdata", mem_wdata, mwdata);
      end
      chk("inst_resp", inst_resp, mb && !mown && mem_resp);
      chk("data_resp", data_resp, mb && mown && mem_resp);
      if (mb && mem_resp) begin
         if (!mown) begin
            chk("inst_rdata", inst_rdata, mem_rdata);
            if (rec) gs = {gs, "I"};
            inst_read = 1'b0;
         end else begin
            if (!mwr) chk("data_rdata", data_rdata, mem_rdata);
            if (rec) gs = {gs, "D"};
            data_read  = 1'b0;
            data_write = 1'b0;
         end
      end
   endtask

   // predict what the coming clock edge does with the current requests
   task automatic commit();
      if (inst_read && !(mb && !mown)) pw++;
      if (mb) begin
         if (mem_resp) mb = 0;
      end else if ((data_read || data_write) &&
                   (!inst_read || mstreak < LIM)) begin
         mb     = 1;
         mown   = 1;
         mwr    = data_write;
         maddr  = data_addr;
         mwdata = data_wdata;
         mmbe   = data_write ? data_mbe : 4'hF;
         if (inst_read) mstreak++;
         pd++;
         mwait  = rnd ? int'($urandom_range(0, 3)) : dwait;
      end else if (inst_read) begin
         mb      = 1;
         mown    = 0;
         mwr     = 0;
         maddr   = inst_addr;
         mmbe    = 4'hF;
         mstreak = 0;
         pi++;
         mwait   = rnd ? int'($urandom_range(0, 3)) : dwait;
      end
   endtask

   task automatic model_reset();
      mb      = 0;
      mstreak = 0;
      pi      = 0;
      pd      = 0;
      pw      = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;

      // reset state
      repeat (2) @(negedge clk);
      observe();
`ifdef ARB_PERF_CNT_EN
      chk("rst_perf_i", perf_i_grants, 32'd0);
      chk("rst_perf_d", perf_d_grants, 32'd0);
      chk("rst_perf_w", perf_i_wait, 32'd0);
`endif
      rst = 1'b0;
      commit();

      // fetch only, two wait states
      observe();
      inst_read  = 1'b1;
      inst_addr  = 32'h60;
      dwait      = 2;
      next_rdata = 32'h0000_0013;
      commit();
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         observe();
         if (c == 0) begin
            chk("fetch_rd", mem_read, 1'b1);
            chk("fetch_addr", mem_addr, 32'h60);
         end
         if (inst_resp) begin
            chk("fetch_data", inst_rdata, 32'h0000_0013);
            chk("fetch_wait", c, 2);
            seen = 1;
         end
         commit();
      end
      chk("fetch_done", seen, 1'b1);

      // store with partial byte enables
      observe();
      data_write = 1'b1;
      data_addr  = 32'h100;
      data_wdata = 32'hDEAD_BEEF;
      data_mbe   = 4'b0011;
      dwait      = 1;
      commit();
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         observe();
         chk("st_wr", mem_write, 1'b1);
         chk("st_rd", mem_read, 1'b0);
         chk("st_mbe", mem_mbe, 4'b0011);
         chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
         if (data_resp) seen = 1;
         commit();
      end
      chk("st_done", seen, 1'b1);
      observe();
      chk("st_pulse", data_resp, 1'b0);
      commit();

      // contention with both ports held high
      observe();
      rst = 1'b1;
      model_reset();
      observe();
      rst        = 1'b0;
      rec        = 1;
      gs         = "";
      dwait      = 0;
      inst_read  = 1'b1;
      inst_addr  = 32'h80;
      data_read  = 1'b1;
      data_addr  = 32'h300;
      commit();
      for (int c = 0; c < 200 && gs.len() < 10; c++) begin
         observe();
         if (gs.len() < 10) begin
            inst_read = 1'b1;
            data_read = 1'b1;
         end else begin
            inst_read = 1'b0;
            data_read = 1'b0;
         end
         commit();
      end
      rec = 0;
      total++;
      assert (gs == "DDDDIDDDDI")
      else begin
         bad++;
         $error("FAIL grant_order obs=%s exp=DDDDIDDDDI", gs);
      end
      observe();
      commit();
`ifdef ARB_PERF_CNT_EN
      chk("perf_d", perf_d_grants, 32'd8);
      chk("perf_i", perf_i_grants, 32'd2);
      chk("perf_w", perf_i_wait, pw);
`endif

      // fetch address changes while the fetch is in flight
      observe();
      inst_read = 1'b1;
      inst_addr = 32'h60;
      dwait     = 3;
      commit();
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         observe();
         inst_addr = 32'h64;
         if (mb) chk("hold_addr", mem_addr, 32'h60);
         if (inst_resp) seen = 1;
         commit();
      end
      chk("hold_done", seen, 1'b1);

      // reset while a load is outstanding
      observe();
      data_read  = 1'b1;
      data_write = 1'b0;
      data_addr  = 32'h200;
      dwait      = 100;
      commit();
      observe();
      chk("rm_busy", mem_read, 1'b1);
      rst       = 1'b1;
      data_read = 1'b0;
      model_reset();
      observe();
      chk("rm_rd", mem_read, 1'b0);
      chk("rm_wr", mem_write, 1'b0);
      rst = 1'b0;
      commit();
      force_resp = 1;
      observe();
      chk("rm_noresp", data_resp, 1'b0);
      chk("rm_noiresp", inst_resp, 1'b0);
      force_resp = 0;
      commit();

      // random traffic
      rnd = 1;
      for (int c = 0; c < 2000; c++) begin
         observe();
         if (!inst_read && $urandom_range(0, 2) == 0) inst_read = 1'b1;
         if (!data_read && !data_write && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1) data_write = 1'b1;
            else data_read = 1'b1;
         end
         inst_addr  = $urandom & 32'hFFFF_FFFC;
         data_addr  = $urandom;
         data_wdata = $urandom;
         data_mbe   = 4'($urandom);
         commit();
      end
      rnd = 0;
      observe();
      commit();
`ifdef ARB_PERF_CNT_EN
      chk("rnd_perf_i", perf_i_grants, pi);
      chk("rnd_perf_d", perf_d_grants, pd);
      chk("rnd_perf_w", perf_i_wait, pw);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipelined datapath.
- Merges its instruction-fetch port (inst_*) and load/store port (data_*) onto one shared word-wide memory port (mem_*).
- Data accesses have priority. A starvation limit forces an instruction grant.
- One transaction is in flight at a time. Responses are routed back to the requester that owns the grant.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses; mbe width is DATA_WIDTH/8.
- STARVE_LIMIT, 4, maximum consecutive data grants while inst_read is pending before an instruction grant is forced. Range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_read  in  1  instruction read request, level, held until inst_resp
- inst_addr  in  ADDR_WIDTH  fetch address
- inst_resp  out  1  one-cycle completion pulse to fetch
- inst_rdata  out  DATA_WIDTH  fetch data, valid only with inst_resp
- data_read  in  1  load request, level
- data_write  in  1  store request, level
- data_mbe  in  DATA_WIDTH/8  store byte enables
- data_addr  in  ADDR_WIDTH  load/store address
- data_wdata  in  DATA_WIDTH  store data
- data_resp  out  1  one-cycle completion pulse to load/store
- data_rdata  out  DATA_WIDTH  load data, valid only with data_resp
- mem_read  out  1  shared-port read strobe
- mem_write  out  1  shared-port write strobe
- mem_mbe  out  DATA_WIDTH/8  shared-port byte enables
- mem_addr  out  ADDR_WIDTH  shared-port address
- mem_wdata  out  DATA_WIDTH  shared-port write data
- mem_rdata  in  DATA_WIDTH  shared-port read data
- mem_resp  in  1  shared-port completion pulse

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, streak=0, latched addr/wdata/mbe=0. All strobes (mem_read, mem_write, inst_resp, data_resp) are 0.
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE arbitration:
  - Data request present (data_read|data_write) and (!inst_read or streak<STARVE_LIMIT): go to D_BUSY. Latch data_addr, data_wdata, and kind (write if data_write, else read). Latch mbe = data_mbe for writes, all-ones for reads. If inst_read is high, streak++ (saturating at STARVE_LIMIT).
  - Otherwise, if inst_read: go to I_BUSY. Latch inst_addr, mbe=all-ones. streak=0.
  - With no request, stay in IDLE and hold streak.
- Busy-state outputs:
  - mem_* are driven from the latched registers only while busy.
  - mem_read=1 in I_BUSY, or in D_BUSY for a read. mem_write=1 in D_BUSY for a write.
  - Upstream address or data changes during busy are ignored.
- Completion: on mem_resp, I_BUSY pulses inst_resp and D_BUSY pulses data_resp in the same cycle, then the FSM returns to IDLE.
- Read data: inst_rdata and data_rdata are combinational copies of mem_rdata.
- Latency: request sampled in IDLE at cycle 0; mem strobe high at cycle 1; resp pulse in the same cycle as mem_resp.
  - Minimum round trip is 2 cycles with a 0-wait memory that responds at cycle 1.
  - At least one IDLE cycle separates consecutive transactions, with mem strobes low in that cycle.
- Simultaneous requests: data wins unless streak==STARVE_LIMIT.
- Both data_read and data_write high: treated as a write. A simulation-only assertion flags it.
- mem_resp while in IDLE: ignored; no upstream response.
- Reset mid-transaction: FSM goes to IDLE and no response is delivered. The upstream must re-request.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_i_grants[31:0], perf_d_grants[31:0], perf_i_wait[31:0].
  - perf_i_wait counts cycles with inst_read high and no I_BUSY grant.
  - All three counters saturate at 2^32-1 and reset to 0.
- When undefined: those ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package arb_types:
  - arb_state_t enum {IDLE, I_BUSY, D_BUSY}.
  - arb_kind_t enum {ARB_RD, ARB_WR}.
  - Constant ARB_MBE_ALL.
- Sub-module arb_streak_counter: saturating counter with clear, increment, and at_limit flag; parameterised by STARVE_LIMIT.

Test Plan:
- Fetch only: inst_read=1, inst_addr=0x60, memory returns 0x00000013 with 2 wait states.
  - mem_read=1 with mem_addr=0x60 at cycle 1.
  - inst_resp pulses with inst_rdata=0x00000013 when mem_resp arrives.
  - data_resp stays 0.
- Store: data_write=1, data_addr=0x100, data_wdata=0xDEADBEEF, data_mbe=0b0011.
  - mem_write=1 with mem_mbe=0b0011 and mem_wdata=0xDEADBEEF.
  - data_resp is a one-cycle pulse and mem_read stays 0.
- Contention: inst_read and data_read held high continuously, STARVE_LIMIT=4.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - No two busy periods are adjacent without an IDLE cycle.
- Address change mid-flight: inst_addr switches from 0x60 to 0x64 during I_BUSY.
  - mem_addr stays 0x60 until mem_resp.
- Reset mid-transaction: rst asserted during D_BUSY, with mem_resp arriving in the cycle after rst deasserts.
  - No data_resp is produced.
  - mem strobes are 0 and the FSM is in IDLE.
- Perf counters with ARB_PERF_CNT_EN defined, after the contention test:
  - perf_d_grants=8, perf_i_grants=2.
  - perf_i_wait equals the measured number of stalled fetch cycles.
